// File: rtl/tdm_demux4.sv
// Time-division 1-to-4 demultiplexer: reassembles sync-aligned serial samples into 4-channel frames.
// Optional macro TDM_DEMUX_FRAME_CNT_EN adds an 8-bit frame_cnt output counting delivered frames.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in,
  input  logic                 sync,
  output logic [4*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic [1:0]           sel,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
  ,
  output logic [7:0]           frame_cnt
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  logic       take_ch0;
  logic       take_mid;
  logic       frame_done;
  logic       err;
  logic [1:0] sel_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state: acquire on any sync sample, lose lock when sync is missing at a frame boundary
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (in_valid && sync) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (in_valid && !sync && (sel == 2'd0)) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Decode of the accepted sample into datapath actions
  always_comb begin
    take_ch0   = 1'b0;
    take_mid   = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;
    sel_nxt    = sel;
    if (in_valid) begin
      if (sync) begin
        // A sync sample always restarts the frame; mid-frame it also discards the partial frame
        take_ch0 = 1'b1;
        sel_nxt  = 2'd1;
        err      = (state == LOCKED) && (sel != 2'd0);
      end else if (state == LOCKED) begin
        if (sel == 2'd0) begin
          err     = 1'b1;
          sel_nxt = 2'd0;
        end else begin
          take_mid   = 1'b1;
          frame_done = (sel == 2'd3);
          sel_nxt    = 2'(sel + 2'd1);
        end
      end else begin
        sel_nxt = 2'd0;
      end
    end
  end

  // Shadow capture, frame delivery and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow0   <= '0;
      shadow1   <= '0;
      shadow2   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      sel       <= 2'd0;
    end else begin
      out_valid <= frame_done;
      sync_err  <= err;
      sel       <= sel_nxt;
      if (take_ch0) shadow0 <= in;
      if (take_mid) begin
        case (sel)
          2'd1:    shadow1 <= in;
          2'd2:    shadow2 <= in;
          default: ;
        endcase
      end
      if (frame_done) out <= {in, shadow2, shadow1, shadow0};
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_FRAME_CNT_EN
  // Counts delivered frames only; wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst)             frame_cnt <= 8'd0;
    else if (frame_done) frame_cnt <= 8'(frame_cnt + 8'd1);
  end
`endif

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side partner of the 4-to-1 channel multiplexer: a time-division 1-to-4 demultiplexer.
- Accepts a serial stream of channel samples, one sample per accepted cycle, in channel order 0,1,2,3. A sync flag marks channel 0.
- Reassembles each frame into a 4-channel parallel word. Channel k lands at the same bit position the mux reads with sel=k.
- Sits after the serial link or mux output. Tracks frame alignment, flags sync errors and presents frame-coherent registered outputs.

Parameters:
- WIDTH, 1, bits per channel sample. Legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high. Sampled on the rising edge of clk.
- in_valid  input  1  the in/sync pair is valid this cycle.
- in  input  WIDTH  serial channel sample.
- sync  input  1  qualifies the current sample as channel 0. Meaningful only when in_valid=1.
- out  output  4*WIDTH  last complete frame; out[WIDTH*k +: WIDTH] = channel k.
- out_valid  output  1  one-cycle pulse when out has just been updated.
- sel  output  2  channel index the next accepted sample will be stored as.
- locked  output  1  frame alignment acquired.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset values (rst=1 at a clk edge): out=0, out_valid=0, sel=0, locked=0, sync_err=0. Shadow registers are cleared and the state is HUNT. Reset mid-frame discards the partial frame. Reset has priority over all other inputs.
- States: HUNT (locked=0) and LOCKED (locked=1).
- HUNT:
  - Samples with sync=0 are dropped.
  - in_valid&sync: store in as shadow ch0, sel<=1, go to LOCKED.
- LOCKED, in_valid=1, sel=1..3, sync=0:
  - Store in to shadow[sel]; sel<=sel+1, wrapping 3->0.
- Frame completion (accepting the sel=3 sample):
  - out <= {in, shadow2, shadow1, shadow0} and out_valid<=1 on the same edge. Both are visible the cycle after the ch3 sample.
  - Latency is 1 cycle from the ch3 sample to out_valid.
- LOCKED, in_valid=1, sel=0, sync=1: normal frame start. Store ch0, sel<=1, no error.
- Early sync (LOCKED, in_valid=1, sel!=0, sync=1):
  - sync_err pulse; the partial frame is discarded (out is not updated).
  - The sample is taken as ch0, sel<=1, state stays LOCKED.
- Missing sync (LOCKED, in_valid=1, sel=0, sync=0):
  - sync_err pulse; the sample is dropped; sel=0; go to HUNT.
- in_valid=0: no state change; sel holds. Gaps of any length inside a frame are tolerated.
- Output stability:
  - out holds its value between frames and changes only together with an out_valid pulse.
  - out_valid and sync_err are never high for more than one consecutive cycle unless new triggering samples arrive.
- sel in HUNT is 0.
- No back-pressure: every in_valid cycle is consumed.

Optional Feature:
- Macro: TDM_DEMUX_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (8 bits), reset value 0.
  - Increments on the same edge that raises out_valid; wraps 255->0.
  - Frames discarded by sync errors are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, sync=1 -> out=0, out_valid=0, sel=0, locked=0, sync_err=0 throughout.
- Aligned frame, WIDTH=1: samples ch0..3 = 0,1,0,1 with sync on ch0 -> locked=1 after ch0; out=4'hA and out_valid=1 for exactly one cycle, the cycle after ch3.
- Gaps: same frame with in_valid=0 for 3 cycles between ch1 and ch2 -> sel holds 2 during the gap; out=4'hA with one out_valid pulse; out unchanged before then.
- Early sync: after an aligned frame giving 4'hA, send ch0, ch1, then a sync sample, then 1,1,1 -> sync_err pulse with no out_valid for the partial frame. New frame = 1,1,1,1 gives out=4'hF (the sync sample has value 1).
- Missing sync at boundary: after frame 4'hA, send a ch0-position sample with sync=0 -> sync_err pulse, locked=0. Further sync=0 samples are ignored; out stays 4'hA.
- Reset mid-frame: after ch1 accepted, rst=1 for 1 cycle -> sel=0, locked=0, out=0. A following aligned frame 1,0,0,0 gives out=4'h1. With TDM_DEMUX_FRAME_CNT_EN defined, frame_cnt=1.
